// File: rtl/elevator_pkg.sv
// elevator_pkg: shared elevator constants and the motor status encoding.
package elevator_pkg;
    localparam int FLOORS          = 3;
    localparam int DEBOUNCE_CYCLES = 4;
    typedef enum logic [1:0] {
        ENGINE_OFF  = 2'b00,
        ENGINE_UP   = 2'b10,
        ENGINE_DOWN = 2'b11
    } engine_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stable-count debouncer and registered rise pulse for one button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic rise
);
    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mismatch, done;
    always_comb begin
        mismatch = sync2_q != level_q;
        done     = mismatch && (cnt_q == 8'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (mismatch && !done) ? cnt_q + 8'd1 : 8'd0;
        level_d  = done ? ~level_q : level_q;
        rise_d   = done & ~level_q;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end
    assign rise = rise_q;
endmodule

// File: rtl/call_register.sv
// call_register: debounces cab and hall buttons into a pending-call vector cleared when the cab is served.
module call_register #(
    parameter int FLOORS          = elevator_pkg::FLOORS,
    parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLOORS-1:0] interior_panel,
    input  logic [FLOORS-1:0] exterior_panel,
    input  logic [FLOORS-1:0] doors,
    input  logic [1:0]        engine,
    output logic [FLOORS-1:0] requests,
    output logic              new_req,
    output logic [1:0]        pending_count
);
    import elevator_pkg::*;
    logic [2*FLOORS-1:0] raw, rise;
    logic [FLOORS-1:0]   press, served, requests_q, requests_d;
    logic                new_req_q, new_req_d;
    logic [1:0]          count_q, count_d;
    assign raw = {exterior_panel, interior_panel};
    genvar i;
    for (i = 0; i < 2*FLOORS; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .CLK (CLK),
            .RST (RST),
            .raw (raw[i]),
            .rise(rise[i])
        );
    end
    // Clear wins over set, so a press at a served floor is simply dropped.
    always_comb begin
        press      = rise[FLOORS-1:0] | rise[2*FLOORS-1:FLOORS];
        served     = doors & {FLOORS{engine == ENGINE_OFF}};
        requests_d = (requests_q | press) & ~served;
        new_req_d  = |(requests_d & ~requests_q);
        count_d    = 2'd0;
        for (int k = 0; k < FLOORS; k++) count_d = count_d + 2'(requests_d[k]);
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            requests_q <= '0;
            new_req_q  <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            requests_q <= requests_d;
            new_req_q  <= new_req_d;
            count_q    <= count_d;
        end
    end
    assign requests      = requests_q;
    assign new_req       = new_req_q;
    assign pending_count = count_q;
endmodule

// File: doc/call_register.md
CALL_REGISTER -- requirements
Module: call_register

Interface
REQ-001 Parameter FLOORS, default 3: number of served floors, one bit per floor in every vector; bit 0 is floor 1, MSB is top floor.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable CLK cycles needed to accept a level change; legal range 2..255.
REQ-003 CLK  input  1  rising-edge system clock.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 interior_panel  input  FLOORS  raw cab buttons, 1 = pressed, asynchronous to CLK.
REQ-006 exterior_panel  input  FLOORS  raw hall buttons, 1 = pressed, asynchronous to CLK.
REQ-007 doors  input  FLOORS  door status from the movement controller, 1 = open at that floor.
REQ-008 engine  input  2  motor status from the movement controller: 00 off, 10 up, 11 down.
REQ-009 requests  output  FLOORS  registered pending-call vector consumed by the movement controller.
REQ-010 new_req  output  1  one-cycle pulse when at least one requests bit goes 0->1.
REQ-011 pending_count  output  2  registered population count of requests (0..3).

Function
REQ-012 Each of the 2*FLOORS raw inputs shall pass through a two-flop synchroniser before any other use.
REQ-013 Each synchronised input shall feed a debouncer whose level changes only after the synchronised value differs from the current level for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle resets its counter.
REQ-014 A press event for floor f shall be the 0->1 transition of the debounced level of interior_panel[f] or exterior_panel[f]; holding the button shall generate no further events.
REQ-015 Served condition for floor f: doors[f]==1 and engine==00, evaluated combinationally on registered inputs.
REQ-016 requests[f] shall set on the CLK edge after a press event for f, unless the served condition for f is true in that cycle, in which case the press is discarded.
REQ-017 requests[f] shall clear on every CLK edge where the served condition for f is true; clear takes priority over a simultaneous set.
REQ-018 An already-set requests[f] shall be unaffected by further press events.
REQ-019 End-to-end latency: a clean raw press held high shall assert requests[f] at rising edge DEBOUNCE_CYCLES+3 after the raw input rises (7 with the default).
REQ-020 A raw pulse shorter than DEBOUNCE_CYCLES cycles, or bouncing with gaps, shall produce no request.
REQ-021 Interior and exterior presses for the same floor in the same cycle shall set requests[f] once and produce one new_req pulse.
REQ-022 new_req shall be registered, asserting in the same cycle that requests shows the new bit.
REQ-023 pending_count shall equal popcount(requests) in the same cycle, never lagging.

Reset
REQ-024 While RST==0: requests=0, new_req=0, pending_count=0, all synchroniser flops, debounced levels and counters = 0.
REQ-025 Assertion mid-debounce shall discard partial counts; after release a button still held shall be accepted as a new press after the full synchroniser and debounce latency.

Structure
REQ-026 The shared package elevator_pkg shall hold FLOORS, DEBOUNCE_CYCLES default and engine encodings ENGINE_OFF=2'b00, ENGINE_UP=2'b10, ENGINE_DOWN=2'b11.
REQ-027 A sub-module btn_debounce (synchroniser + counter + level + rise pulse, one bit) shall be instantiated 2*FLOORS times.

Verification
REQ-028 Reset, press interior_panel=3'b100 held 10 cycles, doors=3'b001, engine=00 -> requests=3'b100 at edge 7, new_req high that cycle only, pending_count=1.
REQ-029 exterior_panel[1] toggles 1,0,1,1,0 each cycle -> requests stays 3'b000, new_req never asserts.
REQ-030 requests=3'b110, then doors=3'b010, engine=00 for 1 cycle -> requests=3'b100, pending_count=1 next edge.
REQ-031 doors=3'b001, engine=00, press interior_panel[0] -> requests[0] stays 0; same press with engine=10 -> requests[0]=1.
REQ-032 interior_panel[2] and exterior_panel[2] pressed on the same cycle -> one new_req pulse, requests=3'b100.
REQ-033 RST asserted at cycle 3 of a held press, released at cycle 5 with button still held -> requests[f] asserts 7 edges after release.
